// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle control sequencer:
// opcode / function / REGIMM selector codes, the sequencer state
// encoding and the byte-lane constants used for memory accesses.
package mips_pkg;

    // Width of the internal state encoding.
    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        FETCH  = 3'd0,
        EXEC1  = 3'd1,
        EXEC2  = 3'd2,
        MDWAIT = 3'd3,
        HALT   = 3'd4
    } state_t;

    // Primary opcodes (instruction[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes (instruction[5:0]).
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // REGIMM selectors (instruction[20:16]).
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Byte-lane enables.
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mips_sequencer_if.sv
// Memory-side bus of the sequencer: effective-address low bits and
// stall in, read/write strobes and byte lanes out.
interface mips_sequencer_if;
    logic [1:0] addr_lo;
    logic       waitrequest;
    logic       MemRead;
    logic       MemWrite;
    logic [3:0] ByteEn;

    modport master (
        input  addr_lo,
        input  waitrequest,
        output MemRead,
        output MemWrite,
        output ByteEn
    );

    modport slave (
        output addr_lo,
        output waitrequest,
        input  MemRead,
        input  MemWrite,
        input  ByteEn
    );
endinterface

// File: rtl/mips_instr_class.sv
// Combinational instruction classifier. Sorts the instruction register
// into the handful of classes the sequencer cares about. LWL/LWR are
// loads with no size flag set: they use all four lanes and are exempt
// from the alignment check. ADD/SUB/ADDI (overflow traps) and all
// coprocessor opcodes are outside the supported subset and decode as
// undefined.
module mips_instr_class
    import mips_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        is_load,
    output logic        is_store,
    output logic        is_word,
    output logic        is_half,
    output logic        is_byte,
    output logic        is_muldiv,
    output logic        writes_reg,
    output logic        undefined
);
    logic [5:0]  opcode;
    logic [5:0]  fncode;
    logic [4:0]  rt;
    logic [14:0] unused_fields;

    assign opcode        = instruction[31:26];
    assign fncode        = instruction[5:0];
    assign rt            = instruction[20:16];
    assign unused_fields = {instruction[25:21], instruction[15:6]};

    // Map opcode/function/rt onto class flags.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_word    = 1'b0;
        is_half    = 1'b0;
        is_byte    = 1'b0;
        is_muldiv  = 1'b0;
        writes_reg = 1'b0;
        undefined  = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (fncode)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_JALR, FN_MFHI, FN_MFLO, FN_ADDU, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        writes_reg = 1'b1;
                    FN_JR, FN_MTHI, FN_MTLO: ;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        is_muldiv = 1'b1;
                    default: undefined = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: ;
                    RT_BLTZAL, RT_BGEZAL: writes_reg = 1'b1;
                    default: undefined = 1'b1;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ;
            OP_JAL, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI:
                writes_reg = 1'b1;
            OP_LB, OP_LBU: begin
                is_load = 1'b1; is_byte = 1'b1; writes_reg = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1; is_half = 1'b1; writes_reg = 1'b1;
            end
            OP_LW: begin
                is_load = 1'b1; is_word = 1'b1; writes_reg = 1'b1;
            end
            OP_LWL, OP_LWR: begin
                is_load = 1'b1; writes_reg = 1'b1;
            end
            OP_SB: begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH: begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW: begin is_store = 1'b1; is_word = 1'b1; end
            default: undefined = 1'b1;
        endcase
    end
endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle control sequencer for the MIPS core. Owns the state
// register, the MULT/DIV latency counter and the sticky fault flag;
// all datapath strobes are decoded combinationally from those plus the
// instruction register and are forced low while rst_n is asserted.
// Build option: define MIPS_SEQ_MEM_WAIT_EN to let waitrequest stall
// FETCH and EXEC2; otherwise memory is fixed-latency and waitrequest
// is ignored. MULDIV_LATENCY legal range is 1..63.
module mips_sequencer
    import mips_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int STATE_W        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instruction,
    input  logic [31:0]        pc,
    mips_sequencer_if.master   mem,
    output logic [STATE_W-1:0] state,
    output logic               active,
    output logic               fault,
    output logic               RegWrite,
    output logic               HiLoWrite,
    output logic               CntEn
);
    localparam int             CNT_W    = $clog2(MULDIV_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] count, count_nxt;
    logic             fault_q, fault_nxt;

    logic is_load, is_store, is_word, is_half, is_byte;
    logic is_muldiv, writes_reg, undefined;
    logic misaligned, stall;
    logic [3:0] lane_be;
    logic rd_c, wr_c, rw_c, hl_c, ce_c, act_c;
    logic [3:0] be_c;

    mips_instr_class u_class (
        .instruction (instruction),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_word     (is_word),
        .is_half     (is_half),
        .is_byte     (is_byte),
        .is_muldiv   (is_muldiv),
        .writes_reg  (writes_reg),
        .undefined   (undefined)
    );

`ifdef MIPS_SEQ_MEM_WAIT_EN
    assign stall = mem.waitrequest;
`else
    logic unused_waitrequest;
    assign unused_waitrequest = mem.waitrequest;
    assign stall = 1'b0;
`endif

    assign misaligned = (is_word && (mem.addr_lo != 2'b00)) || (is_half && mem.addr_lo[0]);
    assign lane_be    = is_half ? (mem.addr_lo[1] ? BE_HALF_HI : BE_HALF_LO)
                      : is_byte ? (BE_BYTE0 << mem.addr_lo)
                      : BE_WORD;

    // State, latency counter and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
            count     <= '0;
            fault_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            cur_state <= nxt_state;
            count     <= count_nxt;
            fault_q   <= fault_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        nxt_state = cur_state;
        count_nxt = count;
        fault_nxt = fault_q;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        be_c      = 4'b0000;
        rw_c      = 1'b0;
        hl_c      = 1'b0;
        ce_c      = 1'b0;
        act_c     = 1'b1;
        unique case (cur_state)
            FETCH: begin
                if (pc == 32'd0) begin
                    act_c     = 1'b0;
                    nxt_state = HALT;
                end else begin
                    rd_c = 1'b1;
                    be_c = BE_WORD;
                    if (!stall) nxt_state = EXEC1;
                end
            end
            EXEC1: begin
                if (undefined || misaligned) begin
                    fault_nxt = 1'b1;
                    nxt_state = HALT;
                end else if (is_muldiv) begin
                    count_nxt = CNT_LOAD;
                    nxt_state = MDWAIT;
                end else if (is_load || is_store) begin
                    nxt_state = EXEC2;
                end else begin
                    rw_c      = writes_reg;
                    ce_c      = 1'b1;
                    nxt_state = FETCH;
                end
            end
            EXEC2: begin
                rd_c = is_load;
                wr_c = is_store;
                be_c = lane_be;
                if (!stall) begin
                    rw_c      = is_load;
                    ce_c      = 1'b1;
                    nxt_state = FETCH;
                end
            end
            MDWAIT: begin
                if (count == '0) begin
                    hl_c      = 1'b1;
                    ce_c      = 1'b1;
                    nxt_state = FETCH;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            HALT: act_c = 1'b0;
            default: begin
                act_c     = 1'b0;
                nxt_state = HALT;
            end
        endcase
    end

    assign mem.MemRead  = rst_n & rd_c;
    assign mem.MemWrite = rst_n & wr_c;
    assign mem.ByteEn   = rst_n ? be_c : 4'b0000;
    assign RegWrite     = rst_n & rw_c;
    assign HiLoWrite    = rst_n & hl_c;
    assign CntEn        = rst_n & ce_c;
    assign active       = rst_n & act_c;
    assign fault        = fault_q;
    assign state        = STATE_W'(cur_state);

endmodule

// File: tb/tb_mips_sequencer.sv
// Scoreboard bench for mips_sequencer. For every instruction the driver
// expands its class into the expected per-cycle output trace, pushes each
// expected cycle into a queue as it drives that cycle, and an independent
// monitor pops and compares on the falling edge. Honours
// MIPS_SEQ_MEM_WAIT_EN the same way the design build does.
`timescale 1ns/1ps
module tb_mips_sequencer;

    localparam int LAT = 4;
`ifdef MIPS_SEQ_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int ST_FETCH  = 0;
    localparam int ST_EXEC1  = 1;
    localparam int ST_EXEC2  = 2;
    localparam int ST_MDWAIT = 3;
    localparam int ST_HALT   = 4;

    typedef enum int {K_ALU, K_MEM, K_MD, K_UNDEF} kind_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] sel;
        kind_t      kind;
        bit         wr;
        bit         ld;
        int         size;
    } ientry_t;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic       flt;
        logic       rd;
        logic       wr;
        logic [3:0] be;
        logic       rw;
        logic       hl;
        logic       ce;
    } obs_t;

    typedef struct {
        logic wreq;
        obs_t e;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        active, fault, RegWrite, HiLoWrite, CntEn;

    mips_sequencer_if bus ();

    mips_sequencer #(.MULDIV_LATENCY(LAT), .STATE_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .pc          (pc),
        .mem         (bus),
        .state       (state),
        .active      (active),
        .fault       (fault),
        .RegWrite    (RegWrite),
        .HiLoWrite   (HiLoWrite),
        .CntEn       (CntEn)
    );

    always #5 clk = ~clk;

    obs_t    exp_q[$];
    step_t   plan[$];
    ientry_t tbl[$];
    ientry_t bad_tbl[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    bit      stim_done = 1'b0;
    bit      tie_wr    = 1'b0;

    function automatic ientry_t ent(input logic [5:0] op, input logic [5:0] sel, input kind_t k,
                                    input bit wr, input bit ld, input int size);
        ientry_t e;
        e.op = op; e.sel = sel; e.kind = k; e.wr = wr; e.ld = ld; e.size = size;
        return e;
    endfunction

    function automatic obs_t mk(input int st, input bit act, input bit flt, input bit rd,
                                input bit wr, input logic [3:0] be, input bit rw,
                                input bit hl, input bit ce);
        obs_t o;
        o.st = 3'(st); o.act = act; o.flt = flt; o.rd = rd; o.wr = wr;
        o.be = be; o.rw = rw; o.hl = hl; o.ce = ce;
        return o;
    endfunction

    function automatic logic [31:0] encode(input ientry_t e);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = e.op;
        if (e.op == 6'h00) r[5:0] = e.sel;
        if (e.op == 6'h01) r[20:16] = e.sel[4:0];
        return r;
    endfunction

    function automatic logic [3:0] lanes(input int size, input logic [1:0] alo);
        logic [3:0] one;
        one = 4'b0001;
        if (size == 1) return one << alo;
        if (size == 2) return alo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Waitrequest value: honoured only when stalls are built in.
    function automatic logic wq(input logic want);
        if (WAIT_EN) return want;
        if (tie_wr) return 1'b1;
        return 1'($urandom);
    endfunction

    // Record one comparison result.
    task automatic check(input bit ok, input string what, input logic [7:0] got_v,
                         input logic [7:0] exp_v);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, required %b", what, $time, got_v, exp_v);
        end
    endtask

    // Expand one instruction into its expected cycle trace.
    task automatic build(input ientry_t e, input logic [31:0] pcv, input logic [1:0] alo,
                         input int fw, input int ew, output bit halts);
        logic [3:0] be;
        bit bad;
        plan.delete();
        halts = 1'b0;
        if (pcv == 32'd0) begin
            plan.push_back('{wq(1'($urandom)), mk(ST_FETCH, 0, 0, 0, 0, 4'h0, 0, 0, 0)});
            halts = 1'b1;
            return;
        end
        for (int i = 0; i < (WAIT_EN ? fw : 0); i++)
            plan.push_back('{wq(1'b1), mk(ST_FETCH, 1, 0, 1, 0, 4'hF, 0, 0, 0)});
        plan.push_back('{wq(1'b0), mk(ST_FETCH, 1, 0, 1, 0, 4'hF, 0, 0, 0)});
        case (e.kind)
            K_ALU:
                plan.push_back('{wq(1'($urandom)), mk(ST_EXEC1, 1, 0, 0, 0, 4'h0, e.wr, 0, 1)});
            K_UNDEF: begin
                plan.push_back('{wq(1'($urandom)), mk(ST_EXEC1, 1, 0, 0, 0, 4'h0, 0, 0, 0)});
                halts = 1'b1;
            end
            K_MD: begin
                plan.push_back('{wq(1'($urandom)), mk(ST_EXEC1, 1, 0, 0, 0, 4'h0, 0, 0, 0)});
                for (int i = 0; i < LAT; i++)
                    plan.push_back('{wq(1'($urandom)),
                                     mk(ST_MDWAIT, 1, 0, 0, 0, 4'h0, 0, i == LAT - 1, i == LAT - 1)});
            end
            default: begin
                bad = (e.size == 4 && alo != 2'b00) || (e.size == 2 && alo[0]);
                be  = lanes(e.size, alo);
                plan.push_back('{wq(1'($urandom)), mk(ST_EXEC1, 1, 0, 0, 0, 4'h0, 0, 0, 0)});
                if (bad) begin
                    halts = 1'b1;
                end else begin
                    for (int i = 0; i < (WAIT_EN ? ew : 0); i++)
                        plan.push_back('{wq(1'b1), mk(ST_EXEC2, 1, 0, e.ld, !e.ld, be, 0, 0, 0)});
                    plan.push_back('{wq(1'b0), mk(ST_EXEC2, 1, 0, e.ld, !e.ld, be, e.ld, 0, 1)});
                end
            end
        endcase
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            bus.waitrequest = 1'($urandom);
            exp_q.push_back(mk(ST_FETCH, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        end
    endtask

    task automatic halt_hold(input int n, input bit flt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.waitrequest = 1'($urandom);
            exp_q.push_back(mk(ST_HALT, 0, flt, 0, 0, 4'h0, 0, 0, 0));
        end
    endtask

    // Drive the planned trace; abort_at >= 0 replaces that cycle with a reset.
    task automatic play(input logic [31:0] ins, input logic [31:0] pcv, input logic [1:0] alo,
                        input int abort_at);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(2);
                return;
            end
            @(posedge clk); #1;
            rst_n           = 1'b1;
            instruction     = ins;
            pc              = pcv;
            bus.addr_lo     = alo;
            bus.waitrequest = plan[i].wreq;
            exp_q.push_back(plan[i].e);
        end
    endtask

    task automatic run(input ientry_t e, input logic [31:0] pcv, input logic [1:0] alo,
                       input int fw, input int ew, input int abort_at, input int hold);
        bit h;
        build(e, pcv, alo, fw, ew, h);
        play(encode(e), pcv, alo, abort_at);
        if (h && abort_at < 0) begin
            halt_hold(hold, pcv != 32'd0);
            do_reset(2);
        end
    endtask

    // Monitor: compare each presented cycle against the scoreboard.
    initial begin
        obs_t got, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got.st = state;  got.act = active; got.flt = fault;
                got.rd = bus.MemRead; got.wr = bus.MemWrite; got.be = bus.ByteEn;
                got.rw = RegWrite; got.hl = HiLoWrite; got.ce = CntEn;
                check(got.st === e.st, "state", 8'(got.st), 8'(e.st));
                check(got.act === e.act, "active", 8'(got.act), 8'(e.act));
                check(got.flt === e.flt, "fault", 8'(got.flt), 8'(e.flt));
                check({got.rd, got.wr, got.be} === {e.rd, e.wr, e.be}, "MemRead/MemWrite/ByteEn",
                      8'({got.rd, got.wr, got.be}), 8'({e.rd, e.wr, e.be}));
                check({got.rw, got.hl, got.ce} === {e.rw, e.hl, e.ce}, "RegWrite/HiLoWrite/CntEn",
                      8'({got.rw, got.hl, got.ce}), 8'({e.rw, e.hl, e.ce}));
            end else if (stim_done) begin
                break;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: bench did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        ientry_t e;
        logic [31:0] pcv;
        rst_n = 1'b0; instruction = 32'd0; pc = 32'd4;
        bus.addr_lo = 2'b00; bus.waitrequest = 1'b0;

        tbl.push_back(ent(6'h00, 6'h00, K_ALU, 1, 0, 0));   // SLL
        tbl.push_back(ent(6'h00, 6'h02, K_ALU, 1, 0, 0));   // SRL
        tbl.push_back(ent(6'h00, 6'h07, K_ALU, 1, 0, 0));   // SRAV
        tbl.push_back(ent(6'h00, 6'h08, K_ALU, 0, 0, 0));   // JR
        tbl.push_back(ent(6'h00, 6'h09, K_ALU, 1, 0, 0));   // JALR
        tbl.push_back(ent(6'h00, 6'h10, K_ALU, 1, 0, 0));   // MFHI
        tbl.push_back(ent(6'h00, 6'h11, K_ALU, 0, 0, 0));   // MTHI
        tbl.push_back(ent(6'h00, 6'h12, K_ALU, 1, 0, 0));   // MFLO
        tbl.push_back(ent(6'h00, 6'h13, K_ALU, 0, 0, 0));   // MTLO
        tbl.push_back(ent(6'h00, 6'h18, K_MD,  0, 0, 0));   // MULT
        tbl.push_back(ent(6'h00, 6'h19, K_MD,  0, 0, 0));   // MULTU
        tbl.push_back(ent(6'h00, 6'h1A, K_MD,  0, 0, 0));   // DIV
        tbl.push_back(ent(6'h00, 6'h1B, K_MD,  0, 0, 0));   // DIVU
        tbl.push_back(ent(6'h00, 6'h21, K_ALU, 1, 0, 0));   // ADDU
        tbl.push_back(ent(6'h00, 6'h23, K_ALU, 1, 0, 0));   // SUBU
        tbl.push_back(ent(6'h00, 6'h27, K_ALU, 1, 0, 0));   // NOR
        tbl.push_back(ent(6'h00, 6'h2B, K_ALU, 1, 0, 0));   // SLTU
        tbl.push_back(ent(6'h01, 6'h00, K_ALU, 0, 0, 0));   // BLTZ
        tbl.push_back(ent(6'h01, 6'h01, K_ALU, 0, 0, 0));   // BGEZ
        tbl.push_back(ent(6'h01, 6'h10, K_ALU, 1, 0, 0));   // BLTZAL
        tbl.push_back(ent(6'h01, 6'h11, K_ALU, 1, 0, 0));   // BGEZAL
        tbl.push_back(ent(6'h02, 6'h00, K_ALU, 0, 0, 0));   // J
        tbl.push_back(ent(6'h03, 6'h00, K_ALU, 1, 0, 0));   // JAL
        tbl.push_back(ent(6'h04, 6'h00, K_ALU, 0, 0, 0));   // BEQ
        tbl.push_back(ent(6'h07, 6'h00, K_ALU, 0, 0, 0));   // BGTZ
        tbl.push_back(ent(6'h09, 6'h00, K_ALU, 1, 0, 0));   // ADDIU
        tbl.push_back(ent(6'h0D, 6'h00, K_ALU, 1, 0, 0));   // ORI
        tbl.push_back(ent(6'h0F, 6'h00, K_ALU, 1, 0, 0));   // LUI
        tbl.push_back(ent(6'h20, 6'h00, K_MEM, 0, 1, 1));   // LB
        tbl.push_back(ent(6'h21, 6'h00, K_MEM, 0, 1, 2));   // LH
        tbl.push_back(ent(6'h22, 6'h00, K_MEM, 0, 1, 0));   // LWL
        tbl.push_back(ent(6'h23, 6'h00, K_MEM, 0, 1, 4));   // LW
        tbl.push_back(ent(6'h24, 6'h00, K_MEM, 0, 1, 1));   // LBU
        tbl.push_back(ent(6'h25, 6'h00, K_MEM, 0, 1, 2));   // LHU
        tbl.push_back(ent(6'h26, 6'h00, K_MEM, 0, 1, 0));   // LWR
        tbl.push_back(ent(6'h28, 6'h00, K_MEM, 0, 0, 1));   // SB
        tbl.push_back(ent(6'h29, 6'h00, K_MEM, 0, 0, 2));   // SH
        tbl.push_back(ent(6'h2B, 6'h00, K_MEM, 0, 0, 4));   // SW
        bad_tbl.push_back(ent(6'h3F, 6'h00, K_UNDEF, 0, 0, 0));
        bad_tbl.push_back(ent(6'h10, 6'h00, K_UNDEF, 0, 0, 0));
        bad_tbl.push_back(ent(6'h00, 6'h3F, K_UNDEF, 0, 0, 0));
        bad_tbl.push_back(ent(6'h00, 6'h01, K_UNDEF, 0, 0, 0));
        bad_tbl.push_back(ent(6'h01, 6'h05, K_UNDEF, 0, 0, 0));

        do_reset(3);
        // ADDU from the boot vector, no stalls.
        run(ent(6'h00, 6'h21, K_ALU, 1, 0, 0), 32'hBFC0_0000, 2'b00, 0, 0, -1, 0);
        // SB to lane 2 with a three-cycle stall.
        run(ent(6'h28, 6'h00, K_MEM, 0, 0, 1), 32'hBFC0_0004, 2'b10, 0, 3, -1, 0);
        // MULT through the full latency.
        run(ent(6'h00, 6'h18, K_MD, 0, 0, 0), 32'hBFC0_0008, 2'b00, 1, 0, -1, 0);
        // Misaligned LW: fault, halt held for ten cycles.
        run(ent(6'h23, 6'h00, K_MEM, 0, 1, 4), 32'hBFC0_000C, 2'b01, 0, 0, -1, 10);
        // pc == 0: halt without fault.
        run(ent(6'h00, 6'h21, K_ALU, 1, 0, 0), 32'h0000_0000, 2'b00, 0, 0, -1, 5);
        // Reset during the second MDWAIT cycle.
        run(ent(6'h00, 6'h1A, K_MD, 0, 0, 0), 32'hBFC0_0010, 2'b00, 0, 0, 3, 0);
        // LW with waitrequest stuck high (completes only in the fixed-latency build).
        tie_wr = 1'b1;
        run(ent(6'h23, 6'h00, K_MEM, 0, 1, 4), 32'hBFC0_0014, 2'b00, 0, 0, -1, 0);
        tie_wr = 1'b0;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) e = bad_tbl[$urandom_range(0, bad_tbl.size() - 1)];
            else                            e = tbl[$urandom_range(0, tbl.size() - 1)];
            pcv = $urandom;
            if (pcv == 32'd0) pcv = 32'd4;
            if ($urandom_range(0, 31) == 0) pcv = 32'd0;
            run(e, pcv, 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1, 3);
        end

        @(posedge clk); #1;
        stim_done = 1'b1;
    end

endmodule

// File: doc/mips_sequencer.md
Name: mips_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the MIPS core. It owns the state register that the instruction decoder previously received as an input.
- Adds a memory stall handshake, a multi-cycle MULT/DIV wait state with a latency counter, byte-lane generation for sub-word accesses, and a sticky fault halt.
- Sits between the instruction register/PC and the datapath strobes: memory, register file, HI/LO and PC counter enable.

Parameters:
- MULDIV_LATENCY, 32, cycles spent in MDWAIT for MULT/MULTU/DIV/DIVU; legal range 1..63.
- STATE_W, 3, width of the exported state code.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instruction  in  32  current instruction register contents
- pc  in  32  address of the current instruction
- addr_lo  in  2  low bits of the effective data address (ALU result)
- waitrequest  in  1  memory not ready; stalls FETCH/EXEC2
- state  out  STATE_W  current state code
- active  out  1  high while executing; low in HALT
- fault  out  1  sticky: undefined instruction or misaligned access
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- ByteEn  out  4  byte lanes for the current access
- RegWrite  out  1  register file write enable
- HiLoWrite  out  1  one-cycle HI/LO commit pulse
- CntEn  out  1  PC advance enable

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, counter=0, fault=0.
  - All strobes forced to 0 while rst_n low; ByteEn=0000; active=0.
  - First FETCH occurs on the first edge after rst_n rises.
- States: FETCH=0, EXEC1=1, EXEC2=2, MDWAIT=3, HALT=4.
- FETCH:
  - If pc==0: go to HALT (no memory read issued); fault stays 0.
  - Otherwise: MemRead=1, ByteEn=1111, active=1.
  - waitrequest=1 holds FETCH; waitrequest=0 moves to EXEC1.
- EXEC1:
  - ALU/branch/jump/MFHI/MFLO/MTHI/MTLO: RegWrite per instruction, CntEn=1, go to FETCH.
  - Load/store: go to EXEC2. Alignment is checked here: LW/SW with addr_lo≠0, or LH/LHU/SH with addr_lo[0]=1, sets fault and goes to HALT.
  - MULT/MULTU/DIV/DIVU: counter=MULDIV_LATENCY-1, go to MDWAIT.
  - Undefined opcode or fncode: fault=1, go to HALT.
  - waitrequest is ignored in EXEC1.
- EXEC2:
  - Load: MemRead=1. Store: MemWrite=1.
  - ByteEn rules:
    - word: 1111
    - half: addr_lo[1] ? 1100 : 0011
    - byte: 0001<<addr_lo
  - waitrequest=1 holds EXEC2 with strobes held stable.
  - On release: load asserts RegWrite, CntEn=1, go to FETCH.
  - LWL/LWR: ByteEn=1111; lane merge happens in the datapath.
- MDWAIT:
  - Counter decrements each cycle.
  - At counter==0: HiLoWrite=1 and CntEn=1 for that single cycle, then go to FETCH.
  - MULDIV_LATENCY=1 gives exactly one MDWAIT cycle.
  - Counter width is $clog2(MULDIV_LATENCY+1).
- HALT:
  - Absorbing: all strobes 0, active=0. Only rst_n exits.
- Reset asserted mid-access (EXEC2 stalled, MDWAIT mid-count) aborts immediately; no partial HiLoWrite or RegWrite.
- Strobes are combinational from registered state plus instruction; state/counter/fault are the only flops.

Optional Feature:
- Macro: MIPS_SEQ_MEM_WAIT_EN.
- Defined: waitrequest stalls FETCH and EXEC2 as above.
- Undefined: the waitrequest port remains but is ignored. FETCH and EXEC2 are always single-cycle (fixed-latency memory); synthesis removes the stall logic.

Decomposition:
- Package mips_pkg:
  - opcode/fncode/REGIMM rt localparams
  - state enum (state_t, STATE_W bits)
  - ByteEn constants (BE_WORD, BE_HALF_LO, BE_HALF_HI)
- Sub-module mips_instr_class (combinational): decodes instruction into class flags is_load, is_store, is_word, is_half, is_byte, is_muldiv, writes_reg, undefined. mips_sequencer instantiates it once.

Test Plan:
- Reset then ADDU at pc=0xBFC00000, waitrequest=0 → FETCH→EXEC1→FETCH. RegWrite=1 and CntEn=1 in EXEC1 only; total 2 cycles.
- SB with addr_lo=2'b10, waitrequest high 3 cycles in EXEC2 → MemWrite=1 and ByteEn=0100 held for 4 cycles, then FETCH; CntEn pulses once.
- MULT with MULDIV_LATENCY=4 → exactly 4 MDWAIT cycles; HiLoWrite=1 only on the 4th; then FETCH.
- LW with addr_lo=2'b01 → fault=1, state=HALT after EXEC1; no MemRead in EXEC2; active=0 persists for 10 cycles.
- pc=0 at FETCH → HALT with fault=0, MemRead never asserted. Assert rst_n=0 mid-MDWAIT → state=FETCH asynchronously, HiLoWrite=0.
- Build without MIPS_SEQ_MEM_WAIT_EN, waitrequest tied 1 → LW completes in 3 cycles regardless.
